alu_arbiter: RTL
================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU (ADD/SUB/SLL/NOR/AND/SLT). It accepts operation requests over valid/ready handshakes, grants one at a time, and registers the operands and control onto the ALU input bus. It captures `out`/`zero` and returns them to the granted requester with backpressure. It sits between the core datapath (requester 0) and a secondary client such as a branch-compare or debug unit (requester 1) and the single ALU instance.

## Interface
- `W`, default 32: operand/result width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 2: per-requester request valid; bit i is requester i.
- `req_ready` output 2: per-requester accept; at most one bit high.
- `req_opA0`, `req_opB0` / `req_opA1`, `req_opB1` input W: operands per requester.
- `req_shamt0` / `req_shamt1` input 5: shift amount per requester.
- `req_ctrl0` / `req_ctrl1` input 3: ALU control code per requester.
- `rsp_valid` output 2: one-hot; response valid for the requester that was granted.
- `rsp_ready` input 2: per-requester response accept.
- `rsp_out` output W: captured ALU result.
- `rsp_zero` output 1: captured ALU zero flag.
- `rsp_err` output 1: request carried an illegal control code (110/111).
- `alu_opA`, `alu_opB` output W: registered drive to ALU inputs.
- `alu_shamt` output 5: registered drive to ALU shift amount.
- `alu_ctrl` output 3: registered drive to ALU control.
- `alu_out` input W: ALU result.
- `alu_zero` input 1: ALU zero flag.
- `busy` output 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `req_ready[g]`=1 only for the granted requester g (combinational from `req_valid` and the priority pointer). `req_ready`=0 when no `req_valid` bit is high.
  - On `req_valid[g] & req_ready[g]`: latch that requester's opA/opB/shamt/ctrl into the ALU drive registers, record g, update the pointer, and go to EXEC.
- EXEC: ALU inputs are stable from the registers; the ALU is combinational. At the end of the cycle, capture `alu_out`→`rsp_out`, `alu_zero`→`rsp_zero`, set `rsp_err`, and go to RESP.
- RESP: `rsp_valid[g]`=1 and all `req_ready`=0. Outputs hold until `rsp_ready[g]`, then go to IDLE. `rsp_ready` on the non-granted bit is ignored.
- Illegal ctrl (110/111): accepted normally. Captured result is forced to `rsp_out`=0, `rsp_zero`=0, `rsp_err`=1. The ALU is still driven with the latched code.
- Arbitration (`ALU_ARB_RR_EN` set): 1-bit pointer `last`.
  - Both valid → grant `~last`.
  - Single valid → grant it.
  - `last` updates only on accept.
- Only the request accepted in IDLE is served; requester inputs may change freely outside the accept cycle.

## Timing
- Reset values:
  - State: IDLE.
  - `req_ready`=0 while `rst` is asserted; it follows the IDLE rule after release.
  - `rsp_valid`=0, `rsp_out`=0, `rsp_zero`=0, `rsp_err`=0, `busy`=0.
  - `alu_opA`=0, `alu_opB`=0, `alu_shamt`=0, `alu_ctrl`=000.
  - `last`=1, so requester 0 wins the first tie.
- Latency: accept in cycle N, EXEC in N+1, `rsp_valid` high from N+2.
- If `rsp_ready` is high in N+2, the next accept is in N+3. Minimum issue interval is 3 cycles.
- No bypass: a request cannot be accepted in the same cycle a response completes.
- Response outputs stay constant while `rsp_valid` is high and `rsp_ready` is low.
- Reset mid-operation (EXEC or RESP): the pending operation is discarded and no response is produced. All registers return to their reset values asynchronously.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration as above.
- Undefined: fixed priority. Requester 0 always wins when both are valid, the `last` pointer is not implemented, and requester 1 can starve.

## Structure
- Shared package `alu_pkg`:
  - ALU control code constants: ADD=000, SUB=001, SLL=010, NOR=011, AND=100, SLT=101.
  - Arbiter state enum (IDLE/EXEC/RESP).
  - An `is_legal_ctrl` function.
- One sub-module: `alu_arb_pick`. It is combinational and maps `req_valid[1:0]` and `last` to a one-hot grant. This keeps the RR vs fixed-priority variant isolated.
- The ALU itself is instantiated outside this block, by the parent.

## Test plan
- Single request: req0 ADD opA=5 opB=7 accepted at N → `rsp_valid`=01 at N+2, `rsp_out`=12, `rsp_zero`=0.
- Tie, RR build: both valid continuously, req0 SUB 9-9 and req1 SLT 3<4 → grants 0, 1, 0, 1 in order. Req0 responses give `rsp_out`=0 with `rsp_zero`=1; req1 responses give `rsp_out`=1.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` rises → outputs stable, `req_ready`=00, `busy`=1. Raising `rsp_ready` → IDLE next cycle.
- Illegal code: req1 ctrl=111 → `rsp_valid`=10, `rsp_out`=0, `rsp_zero`=0, `rsp_err`=1.
- Reset in EXEC: assert `rst` one cycle after accept → no `rsp_valid`. After release, `busy`=0 and requester 0 wins the first tie.
- Fixed-priority build: both valid for 4 operations → every grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes, arbiter FSM states
// and the legal-code check.
package alu_pkg;

  localparam logic [2:0] CtrlAdd = 3'b000;
  localparam logic [2:0] CtrlSub = 3'b001;
  localparam logic [2:0] CtrlSll = 3'b010;
  localparam logic [2:0] CtrlNor = 3'b011;
  localparam logic [2:0] CtrlAnd = 3'b100;
  localparam logic [2:0] CtrlSlt = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } arb_state_e;

  // Codes 110 and 111 have no ALU operation behind them.
  function automatic logic is_legal_ctrl(input logic [2:0] ctrl);
    return ctrl <= CtrlSlt;
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational grant selection for the ALU arbiter.
// ALU_ARB_RR_EN defined: round-robin on ties using the last-grant pointer.
// Undefined: fixed priority, requester 0 always wins a tie.
module alu_arb_pick
  import alu_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
  // Tie goes to the requester that was not granted last; otherwise pass valid through.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  // Requester 0 has strict priority.
  always_comb begin
    grant = {req_valid[1] & ~req_valid[0], req_valid[0]};
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared ALU. Accepts one request in IDLE,
// drives the ALU from registers during EXEC, and holds the captured result in RESP
// until the granted requester takes it.
// Configuration macro: ALU_ARB_RR_EN selects round-robin instead of fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_opA0,
  input  logic [W-1:0] req_opB0,
  input  logic [W-1:0] req_opA1,
  input  logic [W-1:0] req_opB1,
  input  logic [4:0]   req_shamt0,
  input  logic [4:0]   req_shamt1,
  input  logic [2:0]   req_ctrl0,
  input  logic [2:0]   req_ctrl1,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] rsp_out,
  output logic         rsp_zero,
  output logic         rsp_err,
  output logic [W-1:0] alu_opA,
  output logic [W-1:0] alu_opB,
  output logic [4:0]   alu_shamt,
  output logic [2:0]   alu_ctrl,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero,
  output logic         busy
);

  arb_state_e   state_q, state_d;
  logic [W-1:0] opa_q, opa_d;
  logic [W-1:0] opb_q, opb_d;
  logic [4:0]   shamt_q, shamt_d;
  logic [2:0]   ctrl_q, ctrl_d;
  logic         gnt_q, gnt_d;
  logic [W-1:0] out_q, out_d;
  logic         zero_q, zero_d;
  logic         err_q, err_d;

  logic [1:0]   grant;
  logic         last;
  logic         accept;
  logic         sel;

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;
  assign last = last_q;

  // Pointer follows the accepted requester only.
  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = sel;
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign last = 1'b1;
`endif

  alu_arb_pick u_pick (
    .req_valid (req_valid),
    .last      (last),
    .grant     (grant)
  );

  // grant is a subset of req_valid, so any grant bit in IDLE is a handshake.
  assign accept = (state_q == StIdle) && (grant != 2'b00);
  assign sel    = grant[1];

  // Ready only in IDLE and never while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == StIdle) && !rst) begin
      req_ready = grant;
    end
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    shamt_d = shamt_q;
    ctrl_d  = ctrl_q;
    gnt_d   = gnt_q;
    out_d   = out_q;
    zero_d  = zero_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          opa_d   = sel ? req_opA1   : req_opA0;
          opb_d   = sel ? req_opB1   : req_opB0;
          shamt_d = sel ? req_shamt1 : req_shamt0;
          ctrl_d  = sel ? req_ctrl1  : req_ctrl0;
          gnt_d   = sel;
          state_d = StExec;
        end
      end
      StExec: begin
        // Illegal codes still drive the ALU but report a zeroed, flagged result.
        if (is_legal_ctrl(ctrl_q)) begin
          out_d  = alu_out;
          zero_d = alu_zero;
          err_d  = 1'b0;
        end else begin
          out_d  = '0;
          zero_d = 1'b0;
          err_d  = 1'b1;
        end
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready[gnt_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      shamt_q <= '0;
      ctrl_q  <= CtrlAdd;
      gnt_q   <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      shamt_q <= shamt_d;
      ctrl_q  <= ctrl_d;
      gnt_q   <= gnt_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from registers only.
  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == StResp) begin
      rsp_valid = gnt_q ? 2'b10 : 2'b01;
    end
  end

  assign rsp_out   = out_q;
  assign rsp_zero  = zero_q;
  assign rsp_err   = err_q;
  assign alu_opA   = opa_q;
  assign alu_opB   = opb_q;
  assign alu_shamt = shamt_q;
  assign alu_ctrl  = ctrl_q;
  assign busy      = (state_q != StIdle);

endmodule
